// File: rtl/mem_access_unit.sv
// mem_access_unit: a single-outstanding load/store unit. Sub-word stores
// are read-modify-write against a word-wide memory with an asynchronous
// read port.
//
// Handshake: a request transfers on a posedge where req_valid && req_ready.
// req_ready is high only in IDLE. While the unit is busy, req_valid is
// ignored and nothing is queued. resp_valid is a one-cycle pulse with no
// back-pressure. resp_err and resp_rdata are meaningful only while
// resp_valid is high.
module mem_access_unit #(
  parameter int WIDTH    = 8,
  parameter int ADD_SIZE = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADD_SIZE-1:0] req_addr,
  input  logic [4*WIDTH-1:0]  req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [4*WIDTH-1:0]  resp_rdata,
  output logic                mem_enable,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [4*WIDTH-1:0]  mem_data,
  input  logic [4*WIDTH-1:0]  mem_q,
  output logic [2:0]          state_dbg
);

  localparam int DW = 4 * WIDTH;
  // Highest start address whose four bytes all fit in memory.
  localparam logic [ADD_SIZE-1:0] LAST_ADDR = {ADD_SIZE{1'b1}} - ADD_SIZE'(3);

  typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, ERR, RESP} state_t;

  state_t          state, next_state;
  logic            accept;
  logic            req_bad;
  logic            lat_we;
  logic [1:0]      lat_size;
  logic            lat_signed;
  logic [DW-1:0]   lat_wdata;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   load_ext;

  assign accept    = req_valid && req_ready;
  assign req_bad   = (req_size == 2'd3) || (req_addr > LAST_ADDR);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state routing and the per-state strobes.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_enable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                 next_state = ERR;
          else if (!req_we)            next_state = LOAD;
          else if (req_size == 2'd2)   next_state = WRITE;
          else                         next_state = READ;
        end
      end
      LOAD:  next_state = RESP;
      READ:  next_state = WRITE;
      WRITE: begin
        mem_enable = 1'b1;
        next_state = RESP;
      end
      ERR:   next_state = RESP;
      RESP: begin
        resp_valid = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Read-modify-write merge: store data overlays the low lane(s) of the read word.
  always_comb begin
    merged = mem_q;
    if (lat_size == 2'd0) merged[WIDTH-1:0]   = lat_wdata[WIDTH-1:0];
    else                  merged[2*WIDTH-1:0] = lat_wdata[2*WIDTH-1:0];
  end

  // Load result: select byte/half/word and zero- or sign-extend it.
  always_comb begin
    case (lat_size)
      2'd0:    load_ext = {{(3*WIDTH){lat_signed & mem_q[WIDTH-1]}}, mem_q[WIDTH-1:0]};
      2'd1:    load_ext = {{(2*WIDTH){lat_signed & mem_q[2*WIDTH-1]}}, mem_q[2*WIDTH-1:0]};
      default: load_ext = mem_q;
    endcase
  end

  // Latched request fields, memory-side registers and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we     <= 1'b0;
      lat_size   <= 2'd0;
      lat_signed <= 1'b0;
      lat_wdata  <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we     <= req_we;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_wdata  <= req_wdata;
        mem_addr   <= req_addr;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
        // Word stores skip the read phase, so the write word is ready now.
        if (next_state == WRITE) mem_data <= req_wdata;
      end
      if (state == LOAD && !lat_we) resp_rdata <= load_ext;
      if (state == READ && lat_we)  mem_data   <= merged;
      if (state == ERR)             resp_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed vector table, reset and
// back-to-back corner sequences, then random requests against a byte-array
// reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_mem;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_enable;
  logic [23:0] mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q;
  logic [2:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  // Device memory holds only the low 256 bytes and the top 256 bytes.
  logic [7:0] dmem    [512];
  logic [7:0] ref_mem [512];

  mem_access_unit #(.WIDTH(8), .ADD_SIZE(24)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  function automatic int idx(input logic [23:0] a);
    return a[23] ? 256 + int'(a[7:0]) : int'(a[7:0]);
  endfunction

  // Memory device: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 512; i++) dmem[i] <= 8'h00;
    end else if (mem_enable) begin
      for (int k = 0; k < 4; k++) dmem[idx(mem_addr + 24'(k))] <= mem_data[8*k +: 8];
      wr_count <= wr_count + 1;
    end
  end

  assign mem_q = {dmem[idx(mem_addr + 24'd3)], dmem[idx(mem_addr + 24'd2)],
                  dmem[idx(mem_addr + 24'd1)], dmem[idx(mem_addr)]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a request expressed as byte-array operations.
  task automatic ref_exec(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [23:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int nwr);
    int n;
    logic [31:0] v;
    rdata = 32'h0; err = 1'b0; lat = 2; nwr = 0;
    if (size == 2'd3 || addr > 24'hFFFFFC) begin
      err = 1'b1;
      return;
    end
    n = 1 << size;
    if (we) begin
      for (int b = 0; b < n; b++) ref_mem[idx(addr + 24'(b))] = wdata[8*b +: 8];
      nwr = 1;
      lat = (n == 4) ? 2 : 3;
    end else begin
      v = 32'h0;
      for (int b = 0; b < n; b++) v = v | (32'(ref_mem[idx(addr + 24'(b))]) << (8*b));
      if (sgn && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
      rdata = v;
    end
  endtask

  // Driver: issue one request from IDLE, observe the response and busy cycles.
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [23:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int nwr);
    int w0;
    logic [31:0] md0;
    int guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    md0 = mem_data;
    w0  = wr_count;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 0; rdata = 32'hx; err = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      check("ready_busy", {31'b0, req_ready}, 32'd0);
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
    check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    if (!we) check("mem_data_hold", mem_data, md0);
    nwr = wr_count - w0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [23:0] addr, input logic [31:0] wdata,
                              input logic [31:0] er, input logic ee, input int el);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  initial begin
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          lt, m_lt, nw, m_nw;
    int          resp_cnt, w0, bad;
    logic        r_we, r_sgn;
    logic [1:0]  r_size;
    logic [23:0] r_addr;
    logic [31:0] r_wdata;

    vecs[0]  = mk(1, 2'd2, 0, 24'h000010, 32'hDEADBEEF, 32'h00000000, 0, 2);
    vecs[1]  = mk(0, 2'd2, 0, 24'h000010, 32'h0,        32'hDEADBEEF, 0, 2);
    vecs[2]  = mk(1, 2'd2, 0, 24'h000020, 32'h11223344, 32'h00000000, 0, 2);
    vecs[3]  = mk(1, 2'd0, 0, 24'h000021, 32'h000000AB, 32'h00000000, 0, 3);
    vecs[4]  = mk(0, 2'd2, 0, 24'h000020, 32'h0,        32'h1122AB44, 0, 2);
    vecs[5]  = mk(1, 2'd2, 0, 24'h000030, 32'h000080F0, 32'h00000000, 0, 2);
    vecs[6]  = mk(0, 2'd0, 1, 24'h000030, 32'h0,        32'hFFFFFFF0, 0, 2);
    vecs[7]  = mk(0, 2'd1, 0, 24'h000030, 32'h0,        32'h000080F0, 0, 2);
    vecs[8]  = mk(0, 2'd1, 1, 24'h000030, 32'h0,        32'hFFFF80F0, 0, 2);
    vecs[9]  = mk(0, 2'd0, 0, 24'h000030, 32'h0,        32'h000000F0, 0, 2);
    vecs[10] = mk(1, 2'd1, 0, 24'h000031, 32'hFFFF5566, 32'h00000000, 0, 3);
    vecs[11] = mk(0, 2'd2, 0, 24'h000030, 32'h0,        32'h005566F0, 0, 2);
    vecs[12] = mk(0, 2'd3, 0, 24'h000040, 32'h0,        32'h00000000, 1, 2);
    vecs[13] = mk(1, 2'd3, 0, 24'h000040, 32'h12345678, 32'h00000000, 1, 2);
    vecs[14] = mk(1, 2'd2, 0, 24'hFFFFFC, 32'hCAFEF00D, 32'h00000000, 0, 2);
    vecs[15] = mk(0, 2'd2, 0, 24'hFFFFFC, 32'h0,        32'hCAFEF00D, 0, 2);
    vecs[16] = mk(0, 2'd2, 0, 24'hFFFFFD, 32'h0,        32'h00000000, 1, 2);
    vecs[17] = mk(0, 2'd0, 0, 24'hFFFFFF, 32'h0,        32'h00000000, 1, 2);
    vecs[18] = mk(1, 2'd0, 0, 24'hFFFFFE, 32'h000000EE, 32'h00000000, 1, 2);
    vecs[19] = mk(0, 2'd1, 1, 24'hFFFFFC, 32'h0,        32'hFFFFF00D, 0, 2);

    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; clr_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 24'h0; req_wdata = 32'h0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'b0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
    check("rst_mem_addr",   {8'b0, mem_addr},    32'd0);
    check("rst_mem_data",   mem_data,            32'd0);
    check("rst_state_idle", {29'b0, state_dbg},  32'd0);
    clr_mem = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      ref_exec(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
               m_rd, m_er, m_lt, m_nw);
      run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              rd, er, lt, nw);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lt), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_writes", i), 32'(nw),
            (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
    end

    // Reset during the WRITE cycle of a half store.
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 24'h000060; req_wdata = 32'h00001234;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_read_no_enable", {31'b0, mem_enable}, 32'd0);
    @(negedge clk);
    check("rmw_write_enable", {31'b0, mem_enable}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_mem_enable", {31'b0, mem_enable}, 32'd0);
    check("abort_mem_addr",   {8'b0, mem_addr},    32'd0);
    check("abort_mem_data",   mem_data,            32'd0);
    check("abort_resp_rdata", resp_rdata,          32'd0);
    check("abort_resp_err",   {31'b0, resp_err},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    // The memory saw enable high at the reset edge, so the half write landed.
    ref_exec(1'b1, 2'd1, 1'b0, 24'h000060, 32'h00001234, m_rd, m_er, m_lt, m_nw);

    // req_valid held high on a byte store: one accept per four cycles.
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 24'h000050; req_wdata = 32'h00000077;
    req_valid = 1'b1;
    resp_cnt = 0;
    w0 = wr_count;
    for (int i = 0; i < 16; i++) begin
      check("hold_ready", {31'b0, req_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (resp_valid) resp_cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold_responses", 32'(resp_cnt), 32'd4);
    check("hold_writes", 32'(wr_count - w0), 32'd4);
    ref_exec(1'b1, 2'd0, 1'b0, 24'h000050, 32'h00000077, m_rd, m_er, m_lt, m_nw);

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_sgn   = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr  = ($urandom_range(0, 3) == 0) ? 24'hFFFFF0 + 24'($urandom_range(0, 15))
                                            : 24'($urandom_range(0, 252));
      r_wdata = $urandom;
      ref_exec(r_we, r_size, r_sgn, r_addr, r_wdata, m_rd, m_er, m_lt, m_nw);
      run_req(r_we, r_size, r_sgn, r_addr, r_wdata, rd, er, lt, nw);
      check("rand_rdata", rd, m_rd);
      check("rand_err", {31'b0, er}, {31'b0, m_er});
      check("rand_latency", 32'(lt), 32'(m_lt));
      check("rand_writes", 32'(nw), 32'(m_nw));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Whole memory image must match the model.
    bad = 0;
    for (int i = 0; i < 512; i++) if (dmem[i] !== ref_mem[i]) bad++;
    check("mem_image_bytes_wrong", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
